// File: rtl/serial_com_pkg.sv
// Shared definitions for the serial_com link: default frame markers, frame-length
// constants, receiver state encoding and a small saturating-counter helper.
package serial_com_pkg;

  localparam logic [15:0] HEADER_DEFAULT    = 16'hA5A5;
  localparam logic [15:0] DELIMITER_DEFAULT = 16'h5A5A;
  localparam int          MARKER_BITS       = 16;
  localparam int          NUM_BYTES_DEFAULT = 3;
  localparam int          MAX_NUM_BYTES     = 8;
  localparam int          BIT_CNT_W         = $clog2(MAX_NUM_BYTES * 8);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    DELIM   = 2'd2
  } serial_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/serial_com_rx_shift16.sv
// 16-bit MSB-first shift window with a saturating fill counter; flags the shift that
// completes 16 fresh bits and whether the resulting window equals the given pattern.
module serial_com_rx_shift16
  import serial_com_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   shift_i,
  input  logic                   clear_i,
  input  logic                   bit_i,
  input  logic [MARKER_BITS-1:0] pattern_i,
  output logic                   last_o,
  output logic                   match_o
);

  logic [MARKER_BITS-1:0] window_q;
  logic [MARKER_BITS-1:0] window_d;
  logic [4:0]             fill_q;

  assign window_d = {window_q[MARKER_BITS-2:0], bit_i};
  assign last_o   = (fill_q >= 5'(MARKER_BITS - 1));
  assign match_o  = last_o && (window_d == pattern_i);

  // Clear wins over shift so the bit that closes a phase never leaks into the next one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      window_q <= '0;
      fill_q   <= '0;
    end else if (clear_i) begin
      fill_q <= '0;
    end else if (shift_i) begin
      window_q <= window_d;
      if (fill_q != 5'(MARKER_BITS)) begin
        fill_q <= fill_q + 5'd1;
      end
    end
  end

endmodule

// File: rtl/serial_com_rx.sv
// Framed serial receiver: hunts for a 16-bit header, assembles NUM_BYTES payload bytes,
// then checks a 16-bit delimiter and reports good/bad frames with saturating counters.
module serial_com_rx
  import serial_com_pkg::*;
#(
  parameter logic [15:0] HEADER    = HEADER_DEFAULT,
  parameter logic [15:0] DELIMITER = DELIMITER_DEFAULT,
  parameter int          NUM_BYTES = NUM_BYTES_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rx_en,
  input  logic                   bit_valid,
  input  logic                   serial_in,
  output logic [7:0]             byte_data,
  output logic                   byte_valid,
  output logic [8*NUM_BYTES-1:0] payload,
  output logic                   frame_valid,
  output logic                   frame_err,
  output logic                   busy,
  output logic [7:0]             good_count,
  output logic [7:0]             err_count
);

  localparam int FRAME_BITS = 8 * NUM_BYTES;

  logic [1:0]            rst_sync_q;
  logic                  rst_n;
  serial_state_e         state_q;
  logic [BIT_CNT_W-1:0]  bit_cnt_q;
  logic [FRAME_BITS-1:0] capture_q;
  logic [FRAME_BITS-1:0] payload_q;
  logic [7:0]            byte_data_q;
  logic                  byte_valid_q;
  logic                  frame_valid_q;
  logic                  frame_err_q;
  logic [7:0]            good_count_q;
  logic [7:0]            err_count_q;

  logic                  step;
  logic                  win_shift;
  logic                  win_clear;
  logic                  win_last;
  logic                  win_match;
  logic [15:0]           win_pattern;

  // Reset asserts immediately but is released only after two clock edges.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  assign step        = bit_valid && rx_en;
  assign win_pattern = (state_q == DELIM) ? DELIMITER : HEADER;
  assign win_shift   = step && (state_q != PAYLOAD);
  assign win_clear   = !rx_en
                    || (step && (state_q == PAYLOAD))
                    || (step && (state_q == HUNT) && win_match)
                    || (step && (state_q == DELIM) && win_last);

  serial_com_rx_shift16 u_shift16 (
    .clk_i     (clock),
    .rst_ni    (rst_n),
    .shift_i   (win_shift),
    .clear_i   (win_clear),
    .bit_i     (serial_in),
    .pattern_i (win_pattern),
    .last_o    (win_last),
    .match_o   (win_match)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      bit_cnt_q     <= '0;
      capture_q     <= '0;
      payload_q     <= '0;
      byte_data_q   <= '0;
      byte_valid_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      good_count_q  <= '0;
      err_count_q   <= '0;
    end else begin
      byte_valid_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      if (!rx_en) begin
        state_q <= HUNT;
      end else if (bit_valid) begin
        unique case (state_q)
          HUNT: begin
            if (win_match) begin
              state_q   <= PAYLOAD;
              bit_cnt_q <= '0;
            end
          end
          PAYLOAD: begin
            capture_q <= {capture_q[FRAME_BITS-2:0], serial_in};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q[2:0] == 3'd7) begin
              byte_data_q  <= {capture_q[6:0], serial_in};
              byte_valid_q <= 1'b1;
            end
            if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
              state_q <= DELIM;
            end
          end
          DELIM: begin
            if (win_last) begin
              state_q <= HUNT;
              if (win_match) begin
                frame_valid_q <= 1'b1;
                payload_q     <= capture_q;
                good_count_q  <= sat_inc8(good_count_q);
              end else begin
                frame_err_q <= 1'b1;
                err_count_q <= sat_inc8(err_count_q);
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign byte_data   = byte_data_q;
  assign byte_valid  = byte_valid_q;
  assign payload     = payload_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign busy        = (state_q != HUNT);
  assign good_count  = good_count_q;
  assign err_count   = err_count_q;

endmodule

// File: doc/serial_com_rx.md
SERIAL_COM_RX -- requirements
Module: serial_com_rx

Interface
REQ-001 Parameter HEADER, default 16'hA5A5, start-header pattern, MSB first.
REQ-002 Parameter DELIMITER, default 16'h5A5A, end-of-frame pattern, MSB first.
REQ-003 Parameter NUM_BYTES, default 3, payload bytes per frame (legal range 1..8).
REQ-004 clock  input  1  system clock; the one clock of the block, shared with the transmitter's bit-rate domain.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 rx_en  input  1  receive enable; low forces the block to hunt and discards any partial frame.
REQ-007 bit_valid  input  1  single-cycle strobe marking one serial bit on serial_in.
REQ-008 serial_in  input  1  serial data, MSB first, sampled only when bit_valid=1.
REQ-009 byte_data  output  8  most recently assembled payload byte.
REQ-010 byte_valid  output  1  one-cycle pulse when byte_data updates.
REQ-011 payload  output  8*NUM_BYTES  payloads of the last good frame, first byte in the top 8 bits.
REQ-012 frame_valid  output  1  one-cycle pulse when a frame with a correct delimiter completes.
REQ-013 frame_err  output  1  one-cycle pulse when the delimiter mismatches.
REQ-014 busy  output  1  high in any state other than HUNT.
REQ-015 good_count  output  8  count of good frames, saturating at 255.
REQ-016 err_count  output  8  count of delimiter errors, saturating at 255.

Function
REQ-017 FSM states: HUNT, PAYLOAD, DELIM; all state and counter updates occur only in cycles with bit_valid=1 and rx_en=1.
REQ-018 HUNT: shift serial_in into a 16-bit window; match when window==HEADER and at least 16 bits have shifted since entering HUNT; on match -> PAYLOAD, bit counter=0.
REQ-019 PAYLOAD: shift bits MSB first into a byte register; after every 8th bit, byte_data and byte_valid assert in the next cycle; after NUM_BYTES*8 bits -> DELIM.
REQ-020 DELIM: shift 16 bits; on the 16th bit, compare the result with DELIMITER.
REQ-021 On a delimiter match, frame_valid pulses, payload loads all captured bytes, and good_count increments, all visible in the cycle after the final delimiter bit; state -> HUNT.
REQ-022 On a delimiter mismatch, frame_err pulses, payload holds its old value, and err_count increments, all visible in the cycle after the final delimiter bit; state -> HUNT.
REQ-023 On any entry to HUNT, the window fill count clears, so delimiter or payload bits never form a header match.
REQ-024 rx_en low in any cycle: state -> HUNT, fill count cleared, no frame_valid/frame_err, payload and counters held.
REQ-025 bit_valid low: all state holds; pulse outputs are low except for their single scheduled cycle.
REQ-026 Counters at 255 hold at 255 and do not wrap.
REQ-027 A back-to-back header immediately after a delimiter is detected, with no idle bits required.
REQ-028 frame_valid and frame_err are mutually exclusive and never assert in the same cycle.

Reset
REQ-029 While reset=0: state=HUNT; window, byte register, and bit counters are 0; byte_data=0; payload=0; all pulses=0; busy=0; both counters=0.
REQ-030 Reset mid-frame aborts the frame with no pulse; after release, the block needs a full 16-bit header before locking.
REQ-031 Reset deassertion is synchronised to clock before use, through a 2-stage release.

Structure
REQ-032 Shared package serial_com_pkg holds HEADER/DELIMITER defaults, the frame-length constants, and the state enumeration, for use by both the transmitter and the receiver.
REQ-033 One sub-module, serial_com_rx_shift16 (16-bit MSB-first shift register with fill counter and compare), serves both HUNT and DELIM.

Verification
REQ-034 Stream A5A5,0A,14,1E,5A5A with rx_en=1 -> byte_valid x3 (0x0A,0x14,0x1E), payload=0x0A141E, frame_valid once, good_count=1.
REQ-035 Same frame with delimiter 5A5B -> frame_err once, err_count=1, payload unchanged, no frame_valid.
REQ-036 Bits 0,1,0,1,1 then a valid frame -> lock on the true header, payload=0x0A141E.
REQ-037 Two frames back-to-back (payload 0A141E then 010203) -> two frame_valid pulses, final payload=0x010203, good_count=2.
REQ-038 rx_en dropped after the 2nd payload byte, then a full frame -> no pulse for the aborted frame; next frame good, good_count=1.
REQ-039 reset asserted during DELIM -> all outputs 0 immediately; a subsequent full frame is received correctly.
